// File: rtl/uart_tx_fifo_ctrl_if.sv
// FIFO-read and serializer handshake bundle for the UART transmit sequencer.
// master = sequencer side, slave = FIFO/serializer side.
interface uart_tx_fifo_ctrl_if #(
   parameter int DATA_W = 8
) ();
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_pop;
   logic              fifo_en;
   logic              tx_ready;
   logic              tx_done;
   logic              tx_start;
   logic [DATA_W-1:0] tx_data;

   modport master (
      input  fifo_empty, fifo_dout, tx_ready, tx_done,
      output fifo_pop, fifo_en, tx_start, tx_data
   );

   modport slave (
      output fifo_empty, fifo_dout, tx_ready, tx_done,
      input  fifo_pop, fifo_en, tx_start, tx_data
   );
endinterface

// File: rtl/uart_tx_fifo_ctrl.sv
// UART transmit sequencer: pops one byte from the TX FIFO when the serializer is idle,
// launches the frame, waits for completion, and reports THRE, a frame count and a timeout error.
module uart_tx_fifo_ctrl #(
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                err_clr,
   output logic                busy,
   output logic                thre,
   output logic                err_timeout,
   output logic [15:0]         byte_cnt,
   uart_tx_fifo_ctrl_if.master bus
);
   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_LOAD,
      S_START,
      S_WAIT_DONE
   } state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  to_cnt_reg, to_cnt_next;
   logic [DATA_W-1:0] tx_data_reg, tx_data_next;
   logic [15:0]       byte_cnt_reg, byte_cnt_next;
   logic              err_reg, err_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         to_cnt_reg   <= '0;
         tx_data_reg  <= '0;
         byte_cnt_reg <= '0;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         to_cnt_reg   <= to_cnt_next;
         tx_data_reg  <= tx_data_next;
         byte_cnt_reg <= byte_cnt_next;
         err_reg      <= err_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      to_cnt_next   = to_cnt_reg;
      tx_data_next  = tx_data_reg;
      byte_cnt_next = byte_cnt_reg;
      err_next      = err_clr ? 1'b0 : err_reg;

      unique case (state_reg)
         S_IDLE: begin
            // Only state that looks at enable/empty/ready, so an in-flight byte always finishes.
            if (enable && !bus.fifo_empty && bus.tx_ready) begin
               state_next = S_POP;
            end
         end
         S_POP: begin
            state_next = S_LOAD;
         end
         S_LOAD: begin
            tx_data_next = bus.fifo_dout;
            state_next   = S_START;
         end
         S_START: begin
            byte_cnt_next = byte_cnt_reg + 16'd1;
            to_cnt_next   = '0;
            state_next    = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (bus.tx_done) begin
               state_next = S_IDLE;
            end else if (to_cnt_reg == CNT_LAST) begin
               // A timeout beats a simultaneous err_clr.
               err_next   = 1'b1;
               state_next = S_IDLE;
            end else begin
               to_cnt_next = to_cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign bus.fifo_pop = (state_reg == S_POP);
   assign bus.tx_start = (state_reg == S_START);
   assign bus.tx_data  = tx_data_reg;
   assign bus.fifo_en  = enable;
   assign busy         = (state_reg != S_IDLE);
   assign thre         = (state_reg == S_IDLE) && bus.fifo_empty;
   assign err_timeout  = err_reg;
   assign byte_cnt     = byte_cnt_reg;
endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Self-checking bench for uart_tx_fifo_ctrl: per-cycle vector table, FIFO/serializer models
// and a push-order scoreboard for the multi-frame sequences.
module tb_uart_tx_fifo_ctrl;
   localparam int DW = 8;
   localparam int TO = 16;

   typedef logic [7:0] byte_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        err_clr = 1'b0;
   logic        busy, thre, err_timeout;
   logic [15:0] byte_cnt;

   uart_tx_fifo_ctrl_if #(.DATA_W(DW)) bus ();

   uart_tx_fifo_ctrl #(.DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .enable(enable), .err_clr(err_clr),
      .busy(busy), .thre(thre), .err_timeout(err_timeout),
      .byte_cnt(byte_cnt), .bus(bus)
   );

   always #5 clk = ~clk;

   // Source select: direct table values or the FIFO/serializer models
   logic  direct = 1'b1;
   logic  d_empty = 1'b1, d_ready = 1'b1, d_done = 1'b0;
   byte_t d_dout = 8'h00;
   logic  m_empty = 1'b1, s_ready = 1'b1, s_done = 1'b0;
   byte_t m_dout = 8'h00;

   always_comb begin
      bus.fifo_empty = direct ? d_empty : m_empty;
      bus.fifo_dout  = direct ? d_dout  : m_dout;
      bus.tx_ready   = direct ? d_ready : s_ready;
      bus.tx_done    = direct ? d_done  : s_done;
   end

   // FIFO model: registered read data, flags an underrun if popped while empty
   byte_t fq[$];
   logic  push_en = 1'b0;
   byte_t push_val = 8'h00;
   logic  underrun = 1'b0;

   always @(posedge clk) begin
      if (!direct && bus.fifo_pop) begin
         if (fq.size() == 0) underrun <= 1'b1;
         else m_dout <= fq.pop_front();
      end
      if (push_en) fq.push_back(push_val);
      m_empty <= (fq.size() == 0);
   end

   // Serializer model: busy after tx_start, tx_done 10 cycles later; hang mode never answers
   logic s_hang = 1'b0;
   int   s_cnt = 0;

   always @(negedge clk) begin
      s_done <= 1'b0;
      if (bus.tx_start && !s_hang) begin
         s_ready <= 1'b0;
         s_cnt   <= 10;
      end else if (s_cnt == 1) begin
         s_done  <= 1'b1;
         s_ready <= 1'b1;
         s_cnt   <= 0;
      end else if (s_cnt > 1) begin
         s_cnt <= s_cnt - 1;
      end
   end

   // Launch monitor
   byte_t mon_data[$];
   int    mon_cnt[$];

   always @(negedge clk) begin
      if (bus.tx_start) begin
         mon_data.push_back(bus.tx_data);
         mon_cnt.push_back(int'(byte_cnt));
      end
   end

   // Checking
   int    total = 0;
   int    bad = 0;
   byte_t exp_q[$];
   int    rd = 0;
   int    exp_launch = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input byte_t b);
      @(negedge clk);
      push_en  = 1'b1;
      push_val = b;
      exp_q.push_back(b);
      @(negedge clk);
      push_en  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      exp_launch = 0;
   endtask

   task automatic wait_idle(input int budget);
      int w = 0;
      while (busy && w < budget) begin
         tick(1);
         w++;
      end
   endtask

   // Wait for n more launches, then compare each against push order and launch count.
   task automatic expect_frames(input int n, input int budget);
      int w = 0;
      while (mon_data.size() < rd + n && w < budget) begin
         tick(1);
         w++;
      end
      chk("frame_count", 32'(mon_data.size() - rd), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (rd >= mon_data.size() || exp_q.size() == 0) break;
         chk("frame_data", 32'(mon_data[rd]), 32'(exp_q.pop_front()));
         chk("frame_cnt", 32'(mon_cnt[rd]), 32'(exp_launch));
         rd++;
         exp_launch++;
      end
   endtask

   typedef struct {
      logic        en, empty;
      byte_t       dout;
      logic        rdy, done;
      logic        pop, start, bsy, thr;
      byte_t       data;
      logic [15:0] cnt;
   } vec_t;

   function automatic vec_t mk(input logic en, input logic empty, input byte_t dout,
                               input logic rdy, input logic done, input logic pop,
                               input logic start, input logic bsy, input logic thr,
                               input byte_t data, input logic [15:0] cnt);
      vec_t v;
      v.en = en; v.empty = empty; v.dout = dout; v.rdy = rdy; v.done = done;
      v.pop = pop; v.start = start; v.bsy = bsy; v.thr = thr; v.data = data; v.cnt = cnt;
      return v;
   endfunction

   vec_t tbl[11];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      byte_t b;

      //             en    empty dout   rdy   done  pop   start busy  thre  data   cnt
      tbl[0]  = mk(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'd0);
      tbl[1]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0);
      tbl[2]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0);
      tbl[3]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0);
      tbl[4]  = mk(1'b0, 1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 16'd0);
      tbl[5]  = mk(1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'd0);
      tbl[6]  = mk(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 16'd0);
      tbl[7]  = mk(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 16'd1);
      tbl[8]  = mk(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 16'd1);
      tbl[9]  = mk(1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 16'd1);
      tbl[10] = mk(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 16'd1);

      // Reset held with random inputs
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         enable  = 1'($urandom_range(0, 1));
         d_empty = 1'($urandom_range(0, 1));
         d_dout  = 8'($urandom);
         d_ready = 1'($urandom_range(0, 1));
         d_done  = 1'($urandom_range(0, 1));
         err_clr = 1'($urandom_range(0, 1));
         #1;
         chk("reset_outputs",
             {2'b0, bus.fifo_pop, bus.tx_start, busy, err_timeout, bus.tx_data, byte_cnt}, 32'd0);
      end
      @(negedge clk);
      enable = 1'b0; d_empty = 1'b1; d_done = 1'b0; d_ready = 1'b1; err_clr = 1'b0;
      rst = 1'b0;
      #1 chk("reset_release_thre", 32'(thre), 32'd1);

      // Per-cycle vectors
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         enable  = tbl[i].en;
         d_empty = tbl[i].empty;
         d_dout  = tbl[i].dout;
         d_ready = tbl[i].rdy;
         d_done  = tbl[i].done;
         #1;
         chk($sformatf("vec%0d", i),
             {3'b0, bus.fifo_pop, bus.tx_start, busy, thre, err_timeout, bus.tx_data, byte_cnt},
             {3'b0, tbl[i].pop, tbl[i].start, tbl[i].bsy, tbl[i].thr, 1'b0, tbl[i].data, tbl[i].cnt});
      end
      rd = mon_data.size();

      // Single byte with exact launch latency
      d_done = 1'b0;
      direct = 1'b0;
      enable = 1'b1;
      do_reset();
      tick(15);
      chk("sb_idle_thre", 32'(thre), 32'd1);
      push(8'hA5);
      chk("sb_c_nopop", 32'(bus.fifo_pop), 32'd0);
      tick(1); chk("sb_pop_c1", 32'(bus.fifo_pop), 32'd1);
      tick(1); chk("sb_load_c2", {30'b0, bus.fifo_pop, bus.tx_start}, 32'd0);
      tick(1); chk("sb_start_c3", 32'(bus.tx_start), 32'd1);
      chk("sb_data", 32'(bus.tx_data), 32'hA5);
      tick(1); chk("sb_cnt", 32'(byte_cnt), 32'd1);
      wait_idle(40);
      chk("sb_busy", 32'(busy), 32'd0);
      chk("sb_thre", 32'(thre), 32'd1);
      expect_frames(1, 5);

      // Burst of random bytes with random push spacing
      do_reset();
      for (int i = 0; i < 20; i++) begin
         push(8'($urandom));
         tick($urandom_range(0, 3));
      end
      expect_frames(20, 600);
      wait_idle(40);
      tick(2);
      chk("burst_cnt", 32'(byte_cnt), 32'd20);
      chk("burst_underrun", 32'(underrun), 32'd0);

      // Enable dropped in LOAD with three bytes queued
      do_reset();
      enable = 1'b0;
      for (int i = 0; i < 3; i++) push(8'($urandom));
      tick(2);
      chk("en_hold_idle", 32'(busy), 32'd0);
      enable = 1'b1;
      w = 0;
      do begin
         tick(1);
         w++;
      end while (!bus.fifo_pop && w < 10);
      chk("en_pop_seen", 32'(bus.fifo_pop), 32'd1);
      tick(1);
      enable = 1'b0;
      tick(40);
      chk("en_one_frame", 32'(mon_data.size() - rd), 32'd1);
      chk("en_idle_busy", 32'(busy), 32'd0);
      chk("en_idle_thre", 32'(thre), 32'd0);
      expect_frames(1, 1);
      enable = 1'b1;
      expect_frames(2, 100);

      // Timeout with simultaneous and later err_clr
      do_reset();
      s_hang = 1'b1;
      tick(15);
      push(8'h5A);
      w = 0;
      while (!bus.tx_start && w < 10) begin
         tick(1);
         w++;
      end
      chk("to_start", 32'(bus.tx_start), 32'd1);
      tick(TO);
      chk("to_last_wait", {30'b0, busy, err_timeout}, 32'b10);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      chk("to_err_set", 32'(err_timeout), 32'd1);
      chk("to_idle", 32'(busy), 32'd0);
      chk("to_thre", 32'(thre), 32'd1);
      tick(3);
      chk("to_sticky", 32'(err_timeout), 32'd1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      chk("to_cleared", 32'(err_timeout), 32'd0);
      expect_frames(1, 1);
      s_hang = 1'b0;

      // Reset during WAIT_DONE
      do_reset();
      tick(15);
      for (int i = 0; i < 3; i++) begin
         b = 8'($urandom);
         push(b);
      end
      w = 0;
      while (mon_data.size() <= rd && w < 20) begin
         tick(1);
         w++;
      end
      tick(3);
      chk("mf_busy_pre", 32'(busy), 32'd1);
      expect_frames(1, 1);
      #2 rst = 1'b1;
      #1;
      chk("mf_idle", 32'(busy), 32'd0);
      chk("mf_cnt", 32'(byte_cnt), 32'd0);
      tick(2);
      rst = 1'b0;
      exp_launch = 0;
      expect_frames(2, 100);
      wait_idle(40);
      tick(2);
      chk("mf_cnt_after", 32'(byte_cnt), 32'd2);
      chk("final_underrun", 32'(underrun), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
